// File: rtl/ascon_perm_ctrl.sv
// ASCON permutation round scheduler: one full round (Pc, Ps, Pl) per clock
// over a 320-bit state {x0,x1,x2,x3,x4}, x0 in the most significant word.
module ascon_perm_ctrl (
    input  logic         clock_i,
    input  logic         resetb_i,
    input  logic         start_i,
    input  logic [3:0]   rounds_i,
    input  logic [319:0] state_i,
    output logic [319:0] state_o,
    output logic [3:0]   round_o,
    output logic         busy_o,
    output logic         done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t         fsm;
    fsm_t         fsm_nxt;
    logic         accept;
    logic [319:0] st;
    logic [3:0]   rnd;

    // Round counter start value: counting always ends at 11, so shorter
    // permutations simply begin later in the constant schedule.
    function automatic logic [3:0] first_round(input logic [3:0] n);
        case (n)
            4'd6:    first_round = 4'd6;
            4'd8:    first_round = 4'd4;
            default: first_round = 4'd0;
        endcase
    endfunction

    function automatic logic [319:0] add_const(input logic [319:0] s, input logic [3:0] r);
        logic [319:0] o;
        o = s;
        o[135:128] = s[135:128] ^ {4'hF - r, r};
        return o;
    endfunction

    function automatic logic [319:0] sub_layer(input logic [319:0] s);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        return {x0, x1, x2, x3, x4};
    endfunction

    // Rotations are right-rotations written as fixed wiring.
    function automatic logic [319:0] lin_layer(input logic [319:0] s);
        logic [63:0] x0, x1, x2, x3, x4;
        {x0, x1, x2, x3, x4} = s;
        x0 = x0 ^ {x0[18:0], x0[63:19]} ^ {x0[27:0], x0[63:28]};
        x1 = x1 ^ {x1[60:0], x1[63:61]} ^ {x1[38:0], x1[63:39]};
        x2 = x2 ^ {x2[0],    x2[63:1]}  ^ {x2[5:0],  x2[63:6]};
        x3 = x3 ^ {x3[9:0],  x3[63:10]} ^ {x3[16:0], x3[63:17]};
        x4 = x4 ^ {x4[6:0],  x4[63:7]}  ^ {x4[40:0], x4[63:41]};
        return {x0, x1, x2, x3, x4};
    endfunction

    function automatic logic [319:0] full_round(input logic [319:0] s, input logic [3:0] r);
        return lin_layer(sub_layer(add_const(s, r)));
    endfunction

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_nxt;
        end
    end

    always_comb begin
        fsm_nxt = fsm;
        accept  = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (fsm)
            IDLE: begin
                if (start_i) begin
                    accept  = 1'b1;
                    fsm_nxt = RUN;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                if (rnd == 4'd11) begin
                    fsm_nxt = DONE;
                end
            end
            DONE: begin
                done_o = 1'b1;
                if (start_i) begin
                    accept  = 1'b1;
                    fsm_nxt = RUN;
                end else begin
                    fsm_nxt = IDLE;
                end
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            st  <= '0;
            rnd <= '0;
        end else if (accept) begin
            st  <= state_i;
            rnd <= first_round(rounds_i);
        end else if (fsm == RUN) begin
            st <= full_round(st, rnd);
            if (rnd != 4'd11) begin
                rnd <= rnd + 4'd1;
            end
        end
    end

    assign state_o = st;
    assign round_o = rnd;

endmodule
